// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU request arbiter:
// FSM state encoding, unit-select codes and the result-width rule.
`timescale 1ns/1ps
package alu_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      WAIT    = 3'd2,
      CAPTURE = 3'd3,
      RESP    = 3'd4
   } state_e;

   localparam logic [1:0] UNIT_ARITH = 2'b00;
   localparam logic [1:0] UNIT_LOGIC = 2'b01;
   localparam logic [1:0] UNIT_CMP   = 2'b10;
   localparam logic [1:0] UNIT_SHIFT = 2'b11;

   // The arithmetic unit can produce a full product, so results are twice the operand width.
   function automatic int res_width(input int op_w);
      return 2 * op_w;
   endfunction

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Requester-side bundle of the ALU arbiter: two command ports and two response ports
// sharing one result bus. master = requesters, slave = arbiter.
`timescale 1ns/1ps
interface alu_req_arbiter_if
   import alu_ctrl_pkg::*;
#(
   parameter int OP_DATA_WIDTH = 16,
   parameter int RES_WIDTH     = res_width(OP_DATA_WIDTH)
);
   logic                     req0_valid;
   logic                     req0_ready;
   logic [3:0]               req0_func;
   logic [OP_DATA_WIDTH-1:0] req0_a;
   logic [OP_DATA_WIDTH-1:0] req0_b;
   logic                     req1_valid;
   logic                     req1_ready;
   logic [3:0]               req1_func;
   logic [OP_DATA_WIDTH-1:0] req1_a;
   logic [OP_DATA_WIDTH-1:0] req1_b;
   logic                     resp0_valid;
   logic                     resp0_ready;
   logic                     resp1_valid;
   logic                     resp1_ready;
   logic [RES_WIDTH-1:0]     resp_data;
   logic                     resp_carry;
   logic                     resp_err;

   modport master (
      output req0_valid, req0_func, req0_a, req0_b,
      output req1_valid, req1_func, req1_a, req1_b,
      output resp0_ready, resp1_ready,
      input  req0_ready, req1_ready, resp0_valid, resp1_valid,
      input  resp_data, resp_carry, resp_err
   );

   modport slave (
      input  req0_valid, req0_func, req0_a, req0_b,
      input  req1_valid, req1_func, req1_a, req1_b,
      input  resp0_ready, resp1_ready,
      output req0_ready, req1_ready, resp0_valid, resp1_valid,
      output resp_data, resp_carry, resp_err
   );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant from the valids, registered
// last-granted pointer that decides ties in favour of the other port.
`timescale 1ns/1ps
module rr_arbiter2 (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] valid_i,
   input  logic       update_i,
   input  logic       served_i,
   output logic [1:0] grant_o
);

   logic last_q;

   // Pointer starts at port 1 so the first tie goes to port 0.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_q <= 1'b1;
      end else if (update_i) begin
         last_q <= served_i;
      end
   end

   always_comb begin
      grant_o = 2'b00;
      case (valid_i)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
         default: grant_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one registered ALU between two requesters, one operation in flight at a time.
// Define ALU_ARB_STATS_EN to add saturating per-port grant counters (grant_cnt0/grant_cnt1).
`timescale 1ns/1ps
module alu_req_arbiter
   import alu_ctrl_pkg::*;
#(
   parameter int OP_DATA_WIDTH = 16,
   parameter int RES_WIDTH     = res_width(OP_DATA_WIDTH)
) (
   input  logic                     CLK,
   input  logic                     RST,
   alu_req_arbiter_if.slave         bus,
   output logic [OP_DATA_WIDTH-1:0] alu_a,
   output logic [OP_DATA_WIDTH-1:0] alu_b,
   output logic [3:0]               alu_func,
   input  logic [RES_WIDTH-1:0]     alu_arith_out,
   input  logic                     alu_carry,
   input  logic                     alu_arith_flag,
   input  logic [OP_DATA_WIDTH-1:0] alu_logic_out,
   input  logic                     alu_logic_flag,
   input  logic [OP_DATA_WIDTH-1:0] alu_shift_out,
   input  logic                     alu_shift_flag,
   input  logic [2:0]               alu_cmp_out,
   input  logic                     alu_cmp_flag
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [15:0]              grant_cnt0,
   output logic [15:0]              grant_cnt1
`endif
);

   state_e                   state_q, state_d;
   logic                     port_q, port_d;
   logic [3:0]               func_q, func_d;
   logic [OP_DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [OP_DATA_WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [3:0]               alu_func_q, alu_func_d;
   logic [RES_WIDTH-1:0]     data_q, data_d;
   logic                     carry_q, carry_d;
   logic                     err_q, err_d;
   logic [1:0]               rvalid_q, rvalid_d;
   logic [1:0]               grant;
   logic [1:0]               req_ready;
   logic                     accept;
   logic                     resp_hs;
   logic                     served;

   rr_arbiter2 u_arb (
      .clk_i    (CLK),
      .rst_i    (RST),
      .valid_i  ({bus.req1_valid, bus.req0_valid}),
      .update_i (served),
      .served_i (port_q),
      .grant_o  (grant)
   );

   // Ready is offered only to the winner, only while idle and out of reset.
   assign req_ready = (state_q == IDLE && !RST) ? grant : 2'b00;
   assign accept    = |req_ready;
   assign resp_hs   = port_q ? bus.resp1_ready : bus.resp0_ready;

   assign bus.req0_ready  = req_ready[0];
   assign bus.req1_ready  = req_ready[1];
   assign bus.resp0_valid = rvalid_q[0];
   assign bus.resp1_valid = rvalid_q[1];
   assign bus.resp_data   = data_q;
   assign bus.resp_carry  = carry_q;
   assign bus.resp_err    = err_q;
   assign alu_a           = alu_a_q;
   assign alu_b           = alu_b_q;
   assign alu_func        = alu_func_q;

   always_comb begin
      // NOTE: every _d defaults to its _q first, so no branch can leave a latch behind.
      state_d    = state_q;
      port_d     = port_q;
      func_d     = func_q;
      a_d        = a_q;
      b_d        = b_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_func_d = alu_func_q;
      data_d     = data_q;
      carry_d    = carry_q;
      err_d      = err_q;
      rvalid_d   = rvalid_q;
      served     = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               port_d  = req_ready[1];
               func_d  = req_ready[1] ? bus.req1_func : bus.req0_func;
               a_d     = req_ready[1] ? bus.req1_a    : bus.req0_a;
               b_d     = req_ready[1] ? bus.req1_b    : bus.req0_b;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            alu_a_d    = a_q;
            alu_b_d    = b_q;
            alu_func_d = func_q;
            state_d    = WAIT;
         end
         WAIT: begin
            state_d = CAPTURE;
         end
         CAPTURE: begin
            case (func_q[3:2])
               UNIT_ARITH: begin
                  data_d  = alu_arith_out;
                  carry_d = alu_carry;
                  err_d   = !alu_arith_flag;
               end
               UNIT_LOGIC: begin
                  data_d  = RES_WIDTH'(alu_logic_out);
                  carry_d = 1'b0;
                  err_d   = !alu_logic_flag;
               end
               UNIT_CMP: begin
                  data_d  = RES_WIDTH'(alu_cmp_out);
                  carry_d = 1'b0;
                  err_d   = !alu_cmp_flag;
               end
               default: begin
                  data_d  = RES_WIDTH'(alu_shift_out);
                  carry_d = 1'b0;
                  err_d   = !alu_shift_flag;
               end
            endcase
            rvalid_d = port_q ? 2'b10 : 2'b01;
            state_d  = RESP;
         end
         RESP: begin
            if (resp_hs) begin
               rvalid_d = 2'b00;
               served   = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         port_q     <= 1'b0;
         func_q     <= '0;
         a_q        <= '0;
         b_q        <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_func_q <= '0;
         data_q     <= '0;
         carry_q    <= 1'b0;
         err_q      <= 1'b0;
         rvalid_q   <= 2'b00;
      end else begin
         // NOTE: non-blocking so every register samples the same pre-edge _d values.
         state_q    <= state_d;
         port_q     <= port_d;
         func_q     <= func_d;
         a_q        <= a_d;
         b_q        <= b_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_func_q <= alu_func_d;
         data_q     <= data_d;
         carry_q    <= carry_d;
         err_q      <= err_d;
         rvalid_q   <= rvalid_d;
      end
   end

`ifdef ALU_ARB_STATS_EN
   logic [15:0] cnt0_q, cnt1_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else if (accept) begin
         if (!port_d && cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
         if (port_d && cnt1_q != 16'hFFFF)  cnt1_q <= cnt1_q + 16'd1;
      end
   end

   assign grant_cnt0 = cnt0_q;
   assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: directed steps plus a random phase, a small registered ALU
// model in the environment, and a response reference computed from the unit rules.
`timescale 1ns/1ps
module tb_alu_req_arbiter;

   localparam int W  = 16;
   localparam int RW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_req_arbiter_if #(.OP_DATA_WIDTH(W), .RES_WIDTH(RW)) bus ();

   logic [W-1:0]  alu_a, alu_b;
   logic [3:0]    alu_func;
   logic [RW-1:0] alu_arith_out  = '0;
   logic          alu_carry      = 1'b0;
   logic          alu_arith_flag = 1'b0;
   logic [W-1:0]  alu_logic_out  = '0;
   logic          alu_logic_flag = 1'b0;
   logic [W-1:0]  alu_shift_out  = '0;
   logic          alu_shift_flag = 1'b0;
   logic [2:0]    alu_cmp_out    = '0;
   logic          alu_cmp_flag   = 1'b0;
`ifdef ALU_ARB_STATS_EN
   logic [15:0]   grant_cnt0, grant_cnt1;
`endif

   alu_req_arbiter #(.OP_DATA_WIDTH(W), .RES_WIDTH(RW)) dut (
      .CLK            (clk),
      .RST            (rst),
      .bus            (bus),
      .alu_a          (alu_a),
      .alu_b          (alu_b),
      .alu_func       (alu_func),
      .alu_arith_out  (alu_arith_out),
      .alu_carry      (alu_carry),
      .alu_arith_flag (alu_arith_flag),
      .alu_logic_out  (alu_logic_out),
      .alu_logic_flag (alu_logic_flag),
      .alu_shift_out  (alu_shift_out),
      .alu_shift_flag (alu_shift_flag),
      .alu_cmp_out    (alu_cmp_out),
      .alu_cmp_flag   (alu_cmp_flag)
`ifdef ALU_ARB_STATS_EN
      ,
      .grant_cnt0     (grant_cnt0),
      .grant_cnt1     (grant_cnt1)
`endif
   );

   // ---------------- unit behaviour (returns {carry, result} for arith) ----------------
   function automatic logic [RW:0] f_arith(input logic [1:0] op, input logic [W-1:0] a, b);
      logic [W:0] s;
      case (op)
         2'b00: begin s = {1'b0, a} + {1'b0, b}; return {s[W], 16'h0, s[W-1:0]}; end
         2'b01: begin s = {1'b0, a} - {1'b0, b}; return {s[W], 16'h0, s[W-1:0]}; end
         2'b10: return {1'b0, 32'(a) * 32'(b)};
         default: return {1'b0, 16'h0, a};
      endcase
   endfunction

   function automatic logic [W-1:0] f_logic(input logic [1:0] op, input logic [W-1:0] a, b);
      case (op)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return a ^ b;
         default: return ~(a ^ b);
      endcase
   endfunction

   function automatic logic [2:0] f_cmp(input logic [W-1:0] a, b);
      return {a > b, a < b, a == b};
   endfunction

   function automatic logic [W-1:0] f_shift(input logic [1:0] op, input logic [W-1:0] a, b);
      case (op)
         2'b00:   return a << b[3:0];
         2'b01:   return a >> b[3:0];
         2'b10:   return 16'($signed(a) >>> b[3:0]);
         default: return {a[W-2:0], a[W-1]};
      endcase
   endfunction

   // Registered ALU model: every unit computes every cycle, only the selected unit flags.
   bit kill = 1'b0;
   always @(posedge clk) begin
      {alu_carry, alu_arith_out} <= f_arith(alu_func[1:0], alu_a, alu_b);
      alu_logic_out  <= f_logic(alu_func[1:0], alu_a, alu_b);
      alu_cmp_out    <= f_cmp(alu_a, alu_b);
      alu_shift_out  <= f_shift(alu_func[1:0], alu_a, alu_b);
      alu_arith_flag <= (alu_func[3:2] == 2'b00) && !kill;
      alu_logic_flag <= (alu_func[3:2] == 2'b01) && !kill;
      alu_cmp_flag   <= (alu_func[3:2] == 2'b10) && !kill;
      alu_shift_flag <= (alu_func[3:2] == 2'b11) && !kill;
   end

   // ---------------- reference for the response ----------------
   typedef struct {
      logic [RW-1:0] data;
      logic          carry;
      logic          err;
   } resp_t;

   function automatic resp_t expect_resp(input logic [3:0] f, input logic [W-1:0] a, b,
                                         input bit kl);
      resp_t       r;
      logic [RW:0] ar;
      ar      = f_arith(f[1:0], a, b);
      r.carry = 1'b0;
      r.err   = kl;
      case (f[3:2])
         2'b00:   begin r.data = ar[RW-1:0]; r.carry = ar[RW]; end
         2'b01:   r.data = {16'h0, f_logic(f[1:0], a, b)};
         2'b10:   r.data = {29'h0, f_cmp(a, b)};
         default: r.data = {16'h0, f_shift(f[1:0], a, b)};
      endcase
      return r;
   endfunction

   int vectors     = 0;
   int miscompares = 0;
   bit last_g      = 1'b1;   // port granted last; ties go to the other one
   int acc0        = 0;
   int acc1        = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load_req(input int p, input logic [3:0] f, input logic [W-1:0] a, b);
      if (p == 0) begin bus.req0_func = f; bus.req0_a = a; bus.req0_b = b; end
      else        begin bus.req1_func = f; bus.req1_a = a; bus.req1_b = b; end
   endtask

   task automatic rand_req(input int p);
      load_req(p, 4'($urandom), 16'($urandom), 16'($urandom));
   endtask

   task automatic set_valid(input int p, input bit v);
      if (p == 0) bus.req0_valid = v;
      else        bus.req1_valid = v;
   endtask

   // One full operation: accept, latency, result, optional backpressure, release.
   task automatic serve(input int bp, input bit keep, input bit kl);
      int            p, exp_p;
      bit            got;
      logic [3:0]    f;
      logic [W-1:0]  a, b;
      logic [1:0]    vexp;
      logic [RW-1:0] held;
      resp_t         e;
      got = 1'b0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (bus.req0_ready || bus.req1_ready) begin got = 1'b1; break; end
         @(negedge clk);
      end
      if (!got) begin
         check("accept_timeout", 64'(0), 64'(1));
         return;
      end
      exp_p = (bus.req0_valid && bus.req1_valid) ? (last_g ? 0 : 1) : (bus.req1_valid ? 1 : 0);
      p     = bus.req1_ready ? 1 : 0;
      check("grant_port", 64'(p), 64'(exp_p));
      check("grant_onehot", 64'(bus.req0_ready & bus.req1_ready), 64'(0));
      f = (p == 1) ? bus.req1_func : bus.req0_func;
      a = (p == 1) ? bus.req1_a    : bus.req0_a;
      b = (p == 1) ? bus.req1_b    : bus.req0_b;
      e = expect_resp(f, a, b, kl);
      kill = kl;
      if (p == 0) acc0++; else acc1++;
      vexp = (p == 1) ? 2'b10 : 2'b01;
      @(negedge clk);                       // after accept edge t
      if (keep) rand_req(p); else set_valid(p, 1'b0);
      @(negedge clk);                       // after t+1
      check("issue_alu", {28'h0, alu_func, alu_a, alu_b}, {28'h0, f, a, b});
      check("busy_ready", 64'({bus.req1_ready, bus.req0_ready}), 64'(0));
      @(negedge clk);                       // after t+2
      check("early_valid", 64'({bus.resp1_valid, bus.resp0_valid}), 64'(0));
      @(negedge clk);                       // after t+3
      check("resp_valid", 64'({bus.resp1_valid, bus.resp0_valid}), 64'(vexp));
      check("resp_data", 64'(bus.resp_data), 64'(e.data));
      check("resp_flags", 64'({bus.resp_carry, bus.resp_err}), 64'({e.carry, e.err}));
      kill = 1'b0;
      held = e.data;
      if (p == 1) bus.resp0_ready = 1'b1; else bus.resp1_ready = 1'b1;
      for (int c = 0; c < bp; c++) begin
         @(negedge clk);
         check("bp_hold", {30'h0, bus.resp1_valid, bus.resp0_valid, bus.resp_data},
               {30'h0, vexp, held});
         check("bp_no_accept", 64'({bus.req1_ready, bus.req0_ready}), 64'(0));
      end
      bus.resp0_ready = 1'b1;
      bus.resp1_ready = 1'b1;
      @(negedge clk);
      bus.resp0_ready = 1'b0;
      bus.resp1_ready = 1'b0;
      check("resp_release", 64'({bus.resp1_valid, bus.resp0_valid}), 64'(0));
      last_g = (p == 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req0_valid = 1'b1;   // ready must stay low while reset is held
      bus.req1_valid = 1'b0;
      bus.resp0_ready = 1'b0;
      bus.resp1_ready = 1'b0;
      load_req(0, 4'h0, 16'h0, 16'h0);
      load_req(1, 4'h0, 16'h0, 16'h0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_ready", 64'({bus.req1_ready, bus.req0_ready}), 64'(0));
      check("rst_resp", {29'h0, bus.resp1_valid, bus.resp0_valid, bus.resp_carry, bus.resp_err,
                         bus.resp_data}, 64'(0));
      check("rst_alu", {28'h0, alu_func, alu_a, alu_b}, 64'(0));
      bus.req0_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);

      // single op on port 0: 5 + 3
      load_req(0, 4'b0000, 16'd5, 16'd3);
      bus.req0_valid = 1'b1;
      serve(0, 1'b0, 1'b0);

      // a winner that drops valid before the edge keeps its turn
      bus.req1_valid = 1'b1;
      #1 check("drop_win", 64'(bus.req1_ready), 64'(1));
      bus.req1_valid = 1'b0;
      @(negedge clk);
      bus.req1_valid = 1'b1;
      bus.req0_valid = 1'b1;
      rand_req(0);
      rand_req(1);
      #1 check("drop_keeps_turn", 64'({bus.req1_ready, bus.req0_ready}), 64'(2'b10));

      // contention: both ports valid every cycle
      repeat (4) serve(0, 1'b1, 1'b0);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;

      // backpressure on port 1
      load_req(1, 4'b0010, 16'd300, 16'd200);
      bus.req1_valid = 1'b1;
      serve(10, 1'b0, 1'b0);

      // unit selection and zero extension
      load_req(0, 4'b1000, 16'd7, 16'd7);
      bus.req0_valid = 1'b1;
      serve(0, 1'b0, 1'b0);
      load_req(0, 4'b0110, 16'hF0F0, 16'h0FF0);
      bus.req0_valid = 1'b1;
      serve(0, 1'b0, 1'b0);
      load_req(0, 4'b0000, 16'hFFFF, 16'h0001);   // arithmetic carry out
      bus.req0_valid = 1'b1;
      serve(0, 1'b0, 1'b0);
      load_req(0, 4'b1100, 16'hFFFF, 16'h0001);   // carry must not leak from a shift
      bus.req0_valid = 1'b1;
      serve(0, 1'b0, 1'b0);
      load_req(1, 4'b0101, 16'h1234, 16'h4321);   // unit flag low -> error
      bus.req1_valid = 1'b1;
      serve(1, 1'b0, 1'b1);

      // reset while the operation sits in WAIT
      load_req(0, 4'b0000, 16'd100, 16'd23);
      bus.req0_valid = 1'b1;
      #1 check("abort_accept", 64'(bus.req0_ready), 64'(1));
      @(negedge clk);
      bus.req0_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      last_g = 1'b1;
      acc0 = 0;
      acc1 = 0;
      check("abort_resp", {29'h0, bus.resp1_valid, bus.resp0_valid, bus.resp_carry, bus.resp_err,
                           bus.resp_data}, 64'(0));
      check("abort_alu", {28'h0, alu_func, alu_a, alu_b}, 64'(0));
      repeat (4) begin
         @(negedge clk);
         check("abort_no_resp", 64'({bus.resp1_valid, bus.resp0_valid}), 64'(0));
      end
      load_req(0, 4'b0001, 16'd50, 16'd8);
      bus.req0_valid = 1'b1;
      serve(0, 1'b0, 1'b0);

      // random phase
      for (int i = 0; i < 24; i++) begin
         int v;
         v = $urandom_range(1, 3);
         rand_req(0);
         rand_req(1);
         bus.req0_valid = v[0];
         bus.req1_valid = v[1];
         serve($urandom_range(0, 3), 1'($urandom), ($urandom_range(0, 7) == 0));
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      @(negedge clk);

`ifdef ALU_ARB_STATS_EN
      check("grant_cnt0", 64'(grant_cnt0), 64'(acc0));
      check("grant_cnt1", 64'(grant_cnt1), 64'(acc1));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
